// File: rtl/ioctl_upload_server_if.sv
// Upload-direction ioctl bundle: host read port, core pause handshake, RAM read port.
interface ioctl_upload_server_if #(
    parameter int unsigned ADDR_W = 10
);
    logic               ioctl_upload;
    logic [7:0]         ioctl_index;
    logic               ioctl_rd;
    logic [24:0]        ioctl_addr;
    logic [7:0]         ioctl_din;
    logic               ioctl_wait;
    logic               pause_req;
    logic               pause_ack;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_rd;
    logic [7:0]         ram_q;
    logic               busy;

    // Server side (the upload responder)
    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, pause_ack, ram_q,
        output ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy
    );

    // Environment side (host, game core and RAM)
    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, pause_ack, ram_q,
        input  ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy
    );
endinterface

// File: rtl/ioctl_upload_server.sv
// Serves host byte reads of work RAM over ioctl while the core is paused.
module ioctl_upload_server #(
    parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned RAM_LAT      = 1,
    parameter logic [7:0]  FILL         = 8'hFF
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    ioctl_upload_server_if.slave  io_bus
);
    localparam int unsigned CNT_W = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PAUSE = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_CAPT  = 3'd4;

    logic [2:0]        r_state,     w_nxt_state;
    logic [CNT_W-1:0]  r_cnt,       w_nxt_cnt;
    logic              r_pend,      w_nxt_pend;
    logic [24:0]       r_pend_addr, w_nxt_pend_addr;
    logic [7:0]        r_din,       w_nxt_din;
    logic              r_wait,      w_nxt_wait;
    logic              r_ram_rd,    w_nxt_ram_rd;
    logic [ADDR_W-1:0] r_ram_addr,  w_nxt_ram_addr;
    logic              r_pause_req, w_nxt_pause_req;
    logic              r_busy;

    logic              w_sel;
    logic [24:0]       w_issue_addr;
    logic              w_issue_inr;
    logic              w_rd_inr;

    assign w_sel        = io_bus.ioctl_upload && (io_bus.ioctl_index == UPLOAD_INDEX);
    assign w_rd_inr     = (io_bus.ioctl_addr >> ADDR_W) == 25'd0;
    // A strobe held over from PAUSE takes precedence over a fresh one
    assign w_issue_addr = r_pend ? r_pend_addr : io_bus.ioctl_addr;
    assign w_issue_inr  = (w_issue_addr >> ADDR_W) == 25'd0;

    // State register and all registered outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_din       <= 8'h00;
            r_wait      <= 1'b0;
            r_ram_rd    <= 1'b0;
            r_ram_addr  <= '0;
            r_pause_req <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_pend      <= w_nxt_pend;
            r_pend_addr <= w_nxt_pend_addr;
            r_din       <= w_nxt_din;
            r_wait      <= w_nxt_wait;
            r_ram_rd    <= w_nxt_ram_rd;
            r_ram_addr  <= w_nxt_ram_addr;
            r_pause_req <= w_nxt_pause_req;
            r_busy      <= (w_nxt_state != ST_IDLE);
        end
    end

    // Next-state and next-output decode; session end overrides everything
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cnt       = r_cnt;
        w_nxt_pend      = r_pend;
        w_nxt_pend_addr = r_pend_addr;
        w_nxt_din       = r_din;
        w_nxt_wait      = r_wait;
        w_nxt_ram_rd    = 1'b0;
        w_nxt_ram_addr  = r_ram_addr;
        w_nxt_pause_req = r_pause_req;

        if (!w_sel) begin
            w_nxt_state     = ST_IDLE;
            w_nxt_pend      = 1'b0;
            w_nxt_wait      = 1'b0;
            w_nxt_pause_req = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_state     = ST_PAUSE;
                    w_nxt_pause_req = 1'b1;
                end
                ST_PAUSE: begin
                    w_nxt_pause_req = 1'b1;
                    if (io_bus.pause_ack) begin
                        w_nxt_pend = 1'b0;
                        if ((r_pend || io_bus.ioctl_rd) && w_issue_inr) begin
                            w_nxt_state    = ST_READ;
                            w_nxt_ram_rd   = 1'b1;
                            w_nxt_ram_addr = w_issue_addr[ADDR_W-1:0];
                            w_nxt_wait     = 1'b1;
                            w_nxt_cnt      = CNT_W'(RAM_LAT - 1);
                        end else if (r_pend || io_bus.ioctl_rd) begin
                            w_nxt_state = ST_READY;
                            w_nxt_din   = FILL;
                            w_nxt_wait  = 1'b0;
                        end else begin
                            w_nxt_state = ST_READY;
                        end
                    end else if (io_bus.ioctl_rd && !r_pend) begin
                        w_nxt_pend      = 1'b1;
                        w_nxt_pend_addr = io_bus.ioctl_addr;
                        w_nxt_wait      = 1'b1;
                    end
                end
                ST_READY: begin
                    if (io_bus.ioctl_rd && w_rd_inr) begin
                        w_nxt_state    = ST_READ;
                        w_nxt_ram_rd   = 1'b1;
                        w_nxt_ram_addr = io_bus.ioctl_addr[ADDR_W-1:0];
                        w_nxt_wait     = 1'b1;
                        w_nxt_cnt      = CNT_W'(RAM_LAT - 1);
                    end else if (io_bus.ioctl_rd) begin
                        w_nxt_din = FILL;
                    end
                end
                ST_READ: begin
                    if (r_cnt == '0) begin
                        w_nxt_state = ST_CAPT;
                    end else begin
                        w_nxt_cnt = r_cnt - CNT_W'(1);
                    end
                end
                ST_CAPT: begin
                    w_nxt_state = ST_READY;
                    w_nxt_din   = io_bus.ram_q;
                    w_nxt_wait  = 1'b0;
                end
                default: begin
                    w_nxt_state     = ST_IDLE;
                    w_nxt_pend      = 1'b0;
                    w_nxt_wait      = 1'b0;
                    w_nxt_pause_req = 1'b0;
                end
            endcase
        end
    end

    assign io_bus.ioctl_din  = r_din;
    assign io_bus.ioctl_wait = r_wait;
    assign io_bus.pause_req  = r_pause_req;
    assign io_bus.ram_addr   = r_ram_addr;
    assign io_bus.ram_rd     = r_ram_rd;
    assign io_bus.busy       = r_busy;
endmodule
